bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, XFER cycles without s_rdy_ before forced release; legal range 2..255.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: reset_  input  1  asynchronous active-low reset.
REQ-005 Port: m0_req_ .. m3_req_  input  1 each  master bus request, active-low.
REQ-006 Port: m_as_  input  1  address strobe of current owner, active-low.
REQ-007 Port: s_rdy_  input  1  ready from selected slave, active-low.
REQ-008 Port: m0_grnt_ .. m3_grnt_  output  1 each  bus grant, active-low, registered.
REQ-009 Port: owner  output  2  index of granted master, registered.
REQ-010 Port: bus_busy_  output  1  low while state is XFER.
REQ-011 Port: bus_err_  output  1  one-cycle active-low timeout pulse.

Function
REQ-012 The block SHALL implement states IDLE, GRANT, XFER, RELEASE.
REQ-013 Outputs: at most one grnt_ low at any time; a grnt_ is low only in GRANT or XFER, and the low one is m[owner]_grnt_.
REQ-014 IDLE: no req_ low -> stay; otherwise select the master by round-robin, load owner, enter GRANT; grant low from that same edge (1-cycle request-to-grant latency).
REQ-015 Round-robin: search order owner+1, owner+2, owner+3, owner (mod 4); first master with req_ low wins.
REQ-016 GRANT: m_as_ low -> XFER, clear timeout counter; else m[owner]_req_ high -> RELEASE; else stay.
REQ-017 GRANT with m_as_ low and owner req_ high on the same edge SHALL enter XFER (transfer honoured, no preemption).
REQ-018 XFER: s_rdy_ low -> GRANT; else counter increments; counter == TIMEOUT_CYCLES-1 with s_rdy_ high -> RELEASE, bus_err_ low for exactly that next cycle.
REQ-019 XFER with s_rdy_ low on the timeout edge SHALL complete normally (no bus_err_).
REQ-020 Owner req_ deasserted during XFER SHALL NOT drop the grant; release is evaluated in GRANT after completion.
REQ-021 RELEASE: all grnt_ high, unconditionally -> IDLE; owner retains last value for round-robin.
REQ-022 Minimum grant gap between owners SHALL be 2 cycles (RELEASE, IDLE).
REQ-023 Counter SHALL be 8 bits, saturating never reached beyond TIMEOUT_CYCLES-1, cleared in all states except XFER.
REQ-024 bus_busy_ SHALL be low exactly while state is XFER.
REQ-025 Request inputs changing in GRANT/XFER for non-owners SHALL have no effect until IDLE.

Reset
REQ-026 On reset_ low, asynchronously: state IDLE, owner = 3 (so master 0 wins first), counter 0, all grnt_ high, bus_busy_ high, bus_err_ high.
REQ-027 Reset asserted mid-XFER SHALL abort the transfer immediately with no bus_err_ pulse.
REQ-028 After reset_ release, first arbitration SHALL occur on the first rising edge with reset_ high.

Verification
REQ-029 All four req_ low after reset -> grants in order m0,m1,m2,m3,m0 as each owner releases; owner 0,1,2,3,0; 2-cycle gaps.
REQ-030 m2_req_ low alone in IDLE at edge n -> m2_grnt_ low from edge n, owner=2; m2_req_ high at edge k in GRANT -> all grnt_ high from k, IDLE at k+1.
REQ-031 m1 owner, m_as_ low, s_rdy_ held high, TIMEOUT_CYCLES=16 -> bus_err_ low exactly one cycle after 16th XFER cycle, m1_grnt_ high, state RELEASE.
REQ-032 Same as REQ-031 but s_rdy_ low on the 16th XFER cycle -> no bus_err_, return to GRANT with m1_grnt_ still low.
REQ-033 m0 owner, m_as_ low and m0_req_ high same edge -> XFER, bus_busy_ low; s_rdy_ low 3 cycles later -> GRANT then RELEASE next edge.
REQ-034 reset_ low asynchronously during XFER (between edges) -> all grnt_ high and bus_busy_ high immediately, bus_err_ stays high.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low handshakes.
// A master is granted from IDLE, holds the bus through address/transfer
// phases, and is forcibly released if the slave never answers within
// TIMEOUT_CYCLES transfer cycles.

module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    input  logic       m_as_,
    input  logic       s_rdy_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       bus_busy_,
    output logic       bus_err_
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Last counter value a transfer may reach before it is declared hung.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] grnt_q,  grnt_d;
    logic       busy_q,  busy_d;
    logic       err_q,   err_d;

    logic [3:0] req_act;
    logic       rr_found;
    logic [1:0] rr_pick;
    logic [1:0] rr_cand;
    logic       owner_req;
    logic       timeout_hit;

    // Requests are active-low on the pins; work with active-high internally.
    assign req_act   = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req_act[owner_q];

    // A hung transfer: slave still not ready on the last allowed cycle.
    assign timeout_hit = (state_q == XFER) && s_rdy_ && (cnt_q == CNT_LAST);

    // Round-robin search starting just after the current owner, ending on it.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = owner_q;
        rr_cand  = owner_q;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = owner_q + 2'(k);
            if (!rr_found && req_act[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // State, owner, counter and registered outputs, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            cnt_q   <= 8'd0;
            grnt_q  <= 4'hF;
            busy_q  <= 1'b1;
            err_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grnt_q  <= grnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: arbitration, address phase, transfer wait and release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // An address strobe wins over a dropped request so a started
                // transfer is never pre-empted.
                if (!m_as_) begin
                    state_d = XFER;
                end else if (!owner_req) begin
                    state_d = RELEASE;
                end
            end
            XFER: begin
                if (!s_rdy_) begin
                    state_d = GRANT;
                end else if (timeout_hit) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner only changes when a new master is picked out of IDLE; the
    // counter only runs while a transfer keeps waiting.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = 8'd0;
        if (state_q == IDLE && rr_found) begin
            owner_d = rr_pick;
        end
        if (state_q == XFER && state_d == XFER) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Output decode from the upcoming state so outputs come straight off flops.
    always_comb begin
        grnt_d = 4'hF;
        if (state_d == GRANT || state_d == XFER) begin
            grnt_d[owner_d] = 1'b0;
        end
        busy_d = (state_d != XFER);
        err_d  = !timeout_hit;
    end

    assign m0_grnt_  = grnt_q[0];
    assign m1_grnt_  = grnt_q[1];
    assign m2_grnt_  = grnt_q[2];
    assign m3_grnt_  = grnt_q[3];
    assign owner     = owner_q;
    assign bus_busy_ = busy_q;
    assign bus_err_  = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter, checked against a
// transaction-level model of the arbitration rules.

module tb_bus_arbiter;

   localparam int TO = 16;

   localparam int PH_IDLE    = 0;
   localparam int PH_GRANTED = 1;
   localparam int PH_XFER    = 2;
   localparam int PH_RELEASE = 3;

   logic clk;
   logic reset_;
   logic m0Req, m1Req, m2Req, m3Req;
   logic mAs, sRdy;
   logic m0Grnt, m1Grnt, m2Grnt, m3Grnt;
   logic [1:0] owner;
   logic busBusy, busErr;

   int vecCount = 0;
   int errCount = 0;

   int mOwner;
   int mPhase;
   int mWait;
   bit mErr;

   bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .m0_req_   (m0Req),
      .m1_req_   (m1Req),
      .m2_req_   (m2Req),
      .m3_req_   (m3Req),
      .m_as_     (mAs),
      .s_rdy_    (sRdy),
      .m0_grnt_  (m0Grnt),
      .m1_grnt_  (m1Grnt),
      .m2_grnt_  (m2Grnt),
      .m3_grnt_  (m3Grnt),
      .owner     (owner),
      .bus_busy_ (busBusy),
      .bus_err_  (busErr)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count and report every comparison
   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model reset: nobody owns the bus, master 3 counts as last owner
   task automatic modelReset();
      mOwner = 3;
      mPhase = PH_IDLE;
      mWait  = 0;
      mErr   = 1'b0;
   endtask

   // One clock of the arbitration rules, requests given active-low
   task automatic modelStep(input logic [3:0] reqN, input logic asN, input logic rdyN);
      bit errNext;
      bit picked;
      int cand;
      errNext = 1'b0;
      case (mPhase)
         PH_IDLE: begin
            picked = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               cand = (mOwner + k) % 4;
               if (!picked && reqN[cand] == 1'b0) begin
                  picked = 1'b1;
                  mOwner = cand;
               end
            end
            if (picked) mPhase = PH_GRANTED;
         end
         PH_GRANTED: begin
            if (asN == 1'b0) begin
               mPhase = PH_XFER;
               mWait  = 0;
            end else if (reqN[mOwner] == 1'b1) begin
               mPhase = PH_RELEASE;
            end
         end
         PH_XFER: begin
            if (rdyN == 1'b0) begin
               mPhase = PH_GRANTED;
            end else begin
               mWait++;
               if (mWait >= TO) begin
                  mPhase  = PH_RELEASE;
                  errNext = 1'b1;
               end
            end
         end
         default: mPhase = PH_IDLE;
      endcase
      mErr = errNext;
   endtask

   function automatic logic [3:0] dutGrants();
      return {m3Grnt, m2Grnt, m1Grnt, m0Grnt};
   endfunction

   // Compare every DUT output with the model
   task automatic checkAll();
      logic [3:0] expG;
      expG = 4'hF;
      if (mPhase == PH_GRANTED || mPhase == PH_XFER) expG = 4'hF ^ (4'b0001 << mOwner);
      checkOutput("grants", {4'h0, dutGrants()}, {4'h0, expG});
      checkOutput("owner", {6'h0, owner}, 8'(mOwner));
      checkOutput("bus_busy_", {7'h0, busBusy}, {7'h0, !(mPhase == PH_XFER)});
      checkOutput("bus_err_", {7'h0, busErr}, {7'h0, !mErr});
   endtask

   // Drive one cycle of inputs on the falling edge, check after the rising edge
   task automatic applyStimulus(input logic [3:0] reqN, input logic asN, input logic rdyN);
      @(negedge clk);
      {m3Req, m2Req, m1Req, m0Req} = reqN;
      mAs  = asN;
      sRdy = rdyN;
      modelStep(reqN, asN, rdyN);
      @(posedge clk);
      #1;
      checkAll();
   endtask

   // Pull reset between edges and check outputs clear without waiting for a clock
   task automatic asyncResetCheck();
      #2;
      reset_ = 1'b0;
      #1;
      checkOutput("rst_grants", {4'h0, dutGrants()}, 8'h0F);
      checkOutput("rst_busy", {7'h0, busBusy}, 8'h01);
      checkOutput("rst_err", {7'h0, busErr}, 8'h01);
      checkOutput("rst_owner", {6'h0, owner}, 8'h03);
      modelReset();
      @(posedge clk);
      #2;
      reset_ = 1'b1;
   endtask

   initial begin
      int rrExp[5] = '{0, 1, 2, 3, 0};
      int rrIdx;
      bit wasFree;
      logic [3:0] r;

      reset_ = 1'b1;
      {m3Req, m2Req, m1Req, m0Req} = 4'hF;
      mAs  = 1'b1;
      sRdy = 1'b1;
      modelReset();
      #1 reset_ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAll();
      @(posedge clk);
      #2 reset_ = 1'b1;

      // All four masters requesting: each owner drops its request once granted
      rrIdx   = 0;
      wasFree = 1'b1;
      for (int c = 0; c < 14; c++) begin
         r = (mPhase == PH_GRANTED) ? (4'b0001 << mOwner) : 4'h0;
         applyStimulus(r, 1'b1, 1'b1);
         if (wasFree && dutGrants() != 4'hF) begin
            if (rrIdx < 5) checkOutput("rr_order", {6'h0, owner}, 8'(rrExp[rrIdx]));
            rrIdx++;
         end
         wasFree = (dutGrants() == 4'hF);
      end
      checkOutput("rr_count", 8'(rrIdx), 8'd5);
      applyStimulus(4'hF, 1'b1, 1'b1);
      applyStimulus(4'hF, 1'b1, 1'b1);

      // Lone request from master 2, then dropped
      applyStimulus(4'b1011, 1'b1, 1'b1);
      applyStimulus(4'b1011, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);

      // Master 1 transfer with slave never ready: forced release
      applyStimulus(4'b1101, 1'b1, 1'b1);
      for (int c = 0; c < TO + 1; c++) applyStimulus(4'b1101, 1'b0, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);

      // Master 1 again, slave answers on the very last allowed cycle
      applyStimulus(4'b1101, 1'b1, 1'b1);
      applyStimulus(4'b1101, 1'b0, 1'b1);
      for (int c = 0; c < TO - 1; c++) applyStimulus(4'b1101, 1'b1, 1'b1);
      applyStimulus(4'b1101, 1'b1, 1'b0);
      applyStimulus(4'b1101, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);

      // Master 0: strobe and request drop together, short transfer
      applyStimulus(4'b1110, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b0, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1'b1);

      // Reset arriving in the middle of a transfer
      applyStimulus(4'b1110, 1'b1, 1'b1);
      applyStimulus(4'b1110, 1'b0, 1'b1);
      applyStimulus(4'b1110, 1'b1, 1'b1);
      checkOutput("pre_rst_busy", {7'h0, busBusy}, 8'h00);
      asyncResetCheck();

      // Random traffic with occasional mid-transfer resets
      for (int c = 0; c < 3000; c++) begin
         r = 4'($urandom);
         applyStimulus(r, ($urandom_range(0, 2) != 0), ($urandom_range(0, 11) != 0));
         if (mPhase == PH_XFER && $urandom_range(0, 149) == 0) asyncResetCheck();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
